// File: rtl/dmem_axi_port_pkg.sv
// Shared types for the data-memory AXI port: load operation codes and the
// transaction state machine encoding.
package my_mips;

    typedef enum logic [2:0] {
        LOP_NONE = 3'd0,
        LB       = 3'd1,
        LBU      = 3'd2,
        LH       = 3'd3,
        LHU      = 3'd4,
        LW       = 3'd5,
        LWL      = 3'd6,
        LWR      = 3'd7
    } load_op_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RADDR = 3'd1,
        ST_RDATA = 3'd2,
        ST_WADDR = 3'd3,
        ST_WRESP = 3'd4
    } dmem_state_t;

    localparam logic [2:0] AXI_SIZE_WORD  = 3'b010;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [7:0] AXI_LEN_SINGLE = 8'd0;

endpackage

// File: rtl/dmem_axi_port_load_align.sv
// Load result alignment: byte/half extraction with sign/zero extension and
// the LWL/LWR merge of memory bytes into the old rt value.
module load_align
    import my_mips::*;
(
    input  logic [31:0] m,
    input  logic [31:0] rt,
    input  logic [1:0]  a,
    input  load_op_t    op,
    output logic [31:0] aligned
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_byte = m[{a, 3'b000} +: 8];
    assign w_half = a[1] ? m[31:16] : m[15:0];

    always_comb begin
        aligned = m;
        case (op)
            LB:  aligned = {{24{w_byte[7]}}, w_byte};
            LBU: aligned = {24'd0, w_byte};
            LH:  aligned = {{16{w_half[15]}}, w_half};
            LHU: aligned = {16'd0, w_half};
            LWL: begin
                case (a)
                    2'd0:    aligned = {m[7:0],  rt[23:0]};
                    2'd1:    aligned = {m[15:0], rt[15:0]};
                    2'd2:    aligned = {m[23:0], rt[7:0]};
                    default: aligned = m;
                endcase
            end
            LWR: begin
                case (a)
                    2'd0:    aligned = m;
                    2'd1:    aligned = {rt[31:24], m[31:8]};
                    2'd2:    aligned = {rt[31:16], m[31:16]};
                    default: aligned = {rt[31:8],  m[31:24]};
                endcase
            end
            default: aligned = m;
        endcase
    end

endmodule

// File: rtl/dmem_axi_port.sv
// Data-memory request responder: performs one load or store at a time as a
// single-beat AXI4 transaction and returns the aligned load result.
module dmem_axi_port
    import my_mips::*;
#(
    parameter int unsigned         ID_W   = 4,
    parameter logic [ID_W-1:0]     AXI_ID = 4'd1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    input  logic [3:0]      req_wen,
    input  logic [31:0]     req_addr,
    input  logic [31:0]     req_wdata,
    input  load_op_t        req_load_op,
    input  logic [31:0]     req_rt_data,
    output logic            req_ready,
    output logic            resp_valid,
    output logic [31:0]     resp_rdata,
    output logic            busy,
    output logic [ID_W-1:0] arid,
    output logic            arvalid,
    output logic [31:0]     araddr,
    output logic [7:0]      arlen,
    output logic [2:0]      arsize,
    output logic [1:0]      arburst,
    input  logic            arready,
    input  logic [ID_W-1:0] rid,
    input  logic [31:0]     rdata,
    input  logic [1:0]      rresp,
    input  logic            rlast,
    input  logic            rvalid,
    output logic            rready,
    output logic [ID_W-1:0] awid,
    output logic            awvalid,
    output logic [31:0]     awaddr,
    output logic [7:0]      awlen,
    output logic [2:0]      awsize,
    output logic [1:0]      awburst,
    input  logic            awready,
    output logic [31:0]     wdata,
    output logic [3:0]      wstrb,
    output logic            wlast,
    output logic            wvalid,
    input  logic            wready,
    input  logic            bvalid,
    input  logic [1:0]      bresp,
    input  logic [ID_W-1:0] bid,
    output logic            bready
);

    dmem_state_t r_state;
    logic [3:0]  r_wen;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    load_op_t    r_op;
    logic [31:0] r_rt;
    logic        r_arvalid;
    logic        r_rready;
    logic        r_awvalid;
    logic        r_wvalid;
    logic        r_bready;
    logic        r_resp_valid;
    logic [31:0] r_resp_rdata;

    logic [31:0] w_aligned;
    logic        w_accept;
    logic        w_aw_done;
    logic        w_w_done;
    logic        w_unused;

    load_align u_align (
        .m       (rdata),
        .rt      (r_rt),
        .a       (r_addr[1:0]),
        .op      (r_op),
        .aligned (w_aligned)
    );

    assign req_ready  = (r_state == ST_IDLE);
    assign busy       = (r_state != ST_IDLE);
    assign resp_valid = r_resp_valid;
    assign resp_rdata = r_resp_rdata;

    assign arid    = AXI_ID;
    assign arvalid = r_arvalid;
    assign araddr  = {r_addr[31:2], 2'b00};
    assign arlen   = AXI_LEN_SINGLE;
    assign arsize  = AXI_SIZE_WORD;
    assign arburst = AXI_BURST_INCR;
    assign rready  = r_rready;

    assign awid    = AXI_ID;
    assign awvalid = r_awvalid;
    assign awaddr  = {r_addr[31:2], 2'b00};
    assign awlen   = AXI_LEN_SINGLE;
    assign awsize  = AXI_SIZE_WORD;
    assign awburst = AXI_BURST_INCR;
    assign wdata   = r_wdata;
    assign wstrb   = r_wen;
    assign wlast   = 1'b1;
    assign wvalid  = r_wvalid;
    assign bready  = r_bready;

    assign w_accept = req_valid && req_ready &&
                      ((req_wen != '0) || (req_load_op != LOP_NONE));

    // AW and W complete independently; a channel counts as done once its valid
    // has dropped or it handshakes in the current cycle.
    assign w_aw_done = !r_awvalid || awready;
    assign w_w_done  = !r_wvalid  || wready;

    assign w_unused = ^{rid, rresp, bresp, bid};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_wen        <= '0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_op         <= LOP_NONE;
            r_rt         <= '0;
            r_arvalid    <= 1'b0;
            r_rready     <= 1'b0;
            r_awvalid    <= 1'b0;
            r_wvalid     <= 1'b0;
            r_bready     <= 1'b0;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= '0;
        end else begin
            r_resp_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_wen   <= req_wen;
                        r_addr  <= req_addr;
                        r_wdata <= req_wdata;
                        r_op    <= req_load_op;
                        r_rt    <= req_rt_data;
                        if (req_wen != '0) begin
                            r_awvalid <= 1'b1;
                            r_wvalid  <= 1'b1;
                            r_state   <= ST_WADDR;
                        end else begin
                            r_arvalid <= 1'b1;
                            r_state   <= ST_RADDR;
                        end
                    end
                end
                ST_RADDR: begin
                    if (arready) begin
                        r_arvalid <= 1'b0;
                        r_rready  <= 1'b1;
                        r_state   <= ST_RDATA;
                    end
                end
                ST_RDATA: begin
                    if (rvalid && rlast) begin
                        r_rready     <= 1'b0;
                        r_resp_valid <= 1'b1;
                        r_resp_rdata <= w_aligned;
                        r_state      <= ST_IDLE;
                    end
                end
                ST_WADDR: begin
                    if (awready) r_awvalid <= 1'b0;
                    if (wready)  r_wvalid  <= 1'b0;
                    if (w_aw_done && w_w_done) begin
                        r_bready <= 1'b1;
                        r_state  <= ST_WRESP;
                    end
                end
                ST_WRESP: begin
                    if (bvalid) begin
                        r_bready     <= 1'b0;
                        r_resp_valid <= 1'b1;
                        r_resp_rdata <= '0;
                        r_state      <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_axi_port.sv
// Directed bench for dmem_axi_port: the AXI slave is driven step by step and
// every expected value below is hand-computed.
module tb_dmem_axi_port;
    import my_mips::*;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic [3:0]  req_wen;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    load_op_t    req_load_op;
    logic [31:0] req_rt_data;
    logic        req_ready;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        busy;
    logic [3:0]  arid;
    logic        arvalid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;
    logic [3:0]  awid;
    logic        awvalid;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;
    logic        bvalid;
    logic [1:0]  bresp;
    logic [3:0]  bid;
    logic        bready;

    int n_tests = 0;
    int n_fail  = 0;

    dmem_axi_port #(.ID_W(4), .AXI_ID(4'd1)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_wen(req_wen), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_load_op(req_load_op), .req_rt_data(req_rt_data),
        .req_ready(req_ready), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .busy(busy),
        .arid(arid), .arvalid(arvalid), .araddr(araddr), .arlen(arlen),
        .arsize(arsize), .arburst(arburst), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid),
        .rready(rready),
        .awid(awid), .awvalid(awvalid), .awaddr(awaddr), .awlen(awlen),
        .awsize(awsize), .awburst(awburst), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bvalid(bvalid), .bresp(bresp), .bid(bid), .bready(bready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Zero-wait load: acceptance, AR handshake, R beat, then response check.
    task automatic do_load(input string tag, input logic [31:0] addr, input load_op_t op,
                           input logic [31:0] rt, input logic [31:0] mem,
                           input logic [31:0] exp);
        req_valid = 1'b1; req_wen = 4'b0000; req_addr = addr; req_wdata = 32'd0;
        req_load_op = op; req_rt_data = rt; arready = 1'b1;
        chk({tag, " req_ready"}, 32'(req_ready), 32'd1);
        step();
        req_valid = 1'b0; req_load_op = LOP_NONE;
        chk({tag, " arvalid"}, 32'(arvalid), 32'd1);
        chk({tag, " araddr"}, araddr, addr & 32'hFFFF_FFFC);
        chk({tag, " busy"}, 32'(busy), 32'd1);
        step();
        arready = 1'b0;
        chk({tag, " arvalid drop"}, 32'(arvalid), 32'd0);
        chk({tag, " rready"}, 32'(rready), 32'd1);
        rvalid = 1'b1; rdata = mem; rlast = 1'b1; rresp = 2'b10;
        step();
        rvalid = 1'b0; rlast = 1'b0; rdata = 32'd0; rresp = 2'b00;
        chk({tag, " resp_valid"}, 32'(resp_valid), 32'd1);
        chk({tag, " resp_rdata"}, resp_rdata, exp);
        chk({tag, " rready drop"}, 32'(rready), 32'd0);
        step();
        chk({tag, " resp_valid pulse"}, 32'(resp_valid), 32'd0);
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_wen = 4'b0000; req_addr = 32'd0;
        req_wdata = 32'd0; req_load_op = LOP_NONE; req_rt_data = 32'd0;
        arready = 1'b0; rid = 4'd1; rdata = 32'd0; rresp = 2'b00; rlast = 1'b0;
        rvalid = 1'b0; awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
        bresp = 2'b00; bid = 4'd1;
        repeat (3) step();

        // Reset state and fixed AXI fields
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst req_ready", 32'(req_ready), 32'd1);
        chk("rst arvalid", 32'(arvalid), 32'd0);
        chk("rst awvalid", 32'(awvalid), 32'd0);
        chk("rst wvalid", 32'(wvalid), 32'd0);
        chk("rst rready", 32'(rready), 32'd0);
        chk("rst bready", 32'(bready), 32'd0);
        chk("rst resp_valid", 32'(resp_valid), 32'd0);
        chk("rst resp_rdata", resp_rdata, 32'd0);
        chk("rst araddr", araddr, 32'd0);
        chk("rst wstrb", 32'(wstrb), 32'd0);
        chk("arlen", 32'(arlen), 32'd0);
        chk("arsize", 32'(arsize), 32'd2);
        chk("arburst", 32'(arburst), 32'd1);
        chk("awlen", 32'(awlen), 32'd0);
        chk("awsize", 32'(awsize), 32'd2);
        chk("awburst", 32'(awburst), 32'd1);
        chk("wlast", 32'(wlast), 32'd1);
        chk("arid", 32'(arid), 32'd1);
        chk("awid", 32'(awid), 32'd1);
        rst = 1'b0;
        step();

        // Request with neither store nor load is ignored
        req_valid = 1'b1; req_addr = 32'h0000_0044;
        step();
        req_valid = 1'b0;
        chk("ignored busy", 32'(busy), 32'd0);
        chk("ignored arvalid", 32'(arvalid), 32'd0);
        chk("ignored awvalid", 32'(awvalid), 32'd0);
        step();
        chk("ignored resp_valid", 32'(resp_valid), 32'd0);

        // Loads and alignment
        do_load("LW", 32'h0000_1004, LW, 32'h0, 32'h1234_5678, 32'h1234_5678);
        do_load("LB", 32'h0000_0103, LB, 32'h0, 32'h80FF_0011, 32'hFFFF_FF80);
        do_load("LBU", 32'h0000_0103, LBU, 32'h0, 32'h80FF_0011, 32'h0000_0080);
        do_load("LWL", 32'h0000_0201, LWL, 32'h1122_3344, 32'hAABB_CCDD, 32'hCCDD_3344);
        do_load("LWR", 32'h0000_0302, LWR, 32'h1122_3344, 32'hAABB_CCDD, 32'h1122_AABB);
        do_load("LH", 32'h0000_0402, LH, 32'h0, 32'h8001_7FFF, 32'hFFFF_8001);
        do_load("LHU", 32'h0000_0500, LHU, 32'h0, 32'h8001_F00F, 32'h0000_F00F);

        // Byte store with AW accepted two cycles before W
        req_valid = 1'b1; req_wen = 4'b0100; req_addr = 32'h0000_2002;
        req_wdata = 32'h00EE_0000; req_load_op = LB;
        step();
        req_valid = 1'b0; req_wen = 4'b0000; req_load_op = LOP_NONE;
        chk("SB awvalid", 32'(awvalid), 32'd1);
        chk("SB wvalid", 32'(wvalid), 32'd1);
        chk("SB arvalid", 32'(arvalid), 32'd0);
        chk("SB awaddr", awaddr, 32'h0000_2000);
        chk("SB wstrb", 32'(wstrb), 32'h4);
        chk("SB wdata", wdata, 32'h00EE_0000);
        awready = 1'b1;
        step();
        awready = 1'b0;
        chk("SB awvalid drop", 32'(awvalid), 32'd0);
        chk("SB wvalid hold", 32'(wvalid), 32'd1);
        chk("SB bready early", 32'(bready), 32'd0);
        step();
        chk("SB wvalid hold2", 32'(wvalid), 32'd1);
        chk("SB bready early2", 32'(bready), 32'd0);
        wready = 1'b1;
        step();
        wready = 1'b0;
        chk("SB wvalid drop", 32'(wvalid), 32'd0);
        chk("SB bready", 32'(bready), 32'd1);
        chk("SB resp early", 32'(resp_valid), 32'd0);
        bvalid = 1'b1; bresp = 2'b11;
        step();
        bvalid = 1'b0; bresp = 2'b00;
        chk("SB resp_valid", 32'(resp_valid), 32'd1);
        chk("SB resp_rdata", resp_rdata, 32'd0);
        chk("SB bready drop", 32'(bready), 32'd0);
        chk("SB busy", 32'(busy), 32'd0);

        // Store followed by a load held on req_valid
        step();
        req_valid = 1'b1; req_wen = 4'b1111; req_addr = 32'h0000_3010;
        req_wdata = 32'h55AA_55AA; req_load_op = LOP_NONE;
        awready = 1'b1; wready = 1'b1;
        step();
        req_wen = 4'b0000; req_addr = 32'h0000_3020; req_load_op = LW; req_rt_data = 32'd0;
        chk("B2B awvalid", 32'(awvalid), 32'd1);
        chk("B2B wvalid", 32'(wvalid), 32'd1);
        chk("B2B req_ready busy", 32'(req_ready), 32'd0);
        step();
        awready = 1'b0; wready = 1'b0;
        chk("B2B aw/w done", 32'({awvalid, wvalid}), 32'd0);
        chk("B2B bready", 32'(bready), 32'd1);
        chk("B2B arvalid wresp", 32'(arvalid), 32'd0);
        bvalid = 1'b1;
        step();
        bvalid = 1'b0;
        chk("B2B st resp_valid", 32'(resp_valid), 32'd1);
        chk("B2B arvalid at resp", 32'(arvalid), 32'd0);
        chk("B2B req_ready", 32'(req_ready), 32'd1);
        arready = 1'b1;
        step();
        req_valid = 1'b0; req_load_op = LOP_NONE;
        chk("B2B ld arvalid", 32'(arvalid), 32'd1);
        chk("B2B ld awvalid", 32'(awvalid), 32'd0);
        chk("B2B ld araddr", araddr, 32'h0000_3020);
        chk("B2B resp_valid pulse", 32'(resp_valid), 32'd0);
        step();
        arready = 1'b0;
        chk("B2B ld rready", 32'(rready), 32'd1);
        rvalid = 1'b1; rlast = 1'b1; rdata = 32'hDEAD_BEEF;
        step();
        rvalid = 1'b0; rlast = 1'b0;
        chk("B2B ld resp_valid", 32'(resp_valid), 32'd1);
        chk("B2B ld resp_rdata", resp_rdata, 32'hDEAD_BEEF);

        // Reset while waiting for read data
        step();
        req_valid = 1'b1; req_addr = 32'h0000_0600; req_load_op = LW; arready = 1'b1;
        step();
        req_valid = 1'b0; req_load_op = LOP_NONE;
        step();
        arready = 1'b0;
        chk("RST in RDATA rready", 32'(rready), 32'd1);
        rst = 1'b1; rvalid = 1'b1; rlast = 1'b1; rdata = 32'hCAFE_F00D;
        step();
        rst = 1'b0; rvalid = 1'b0; rlast = 1'b0;
        chk("RST busy", 32'(busy), 32'd0);
        chk("RST rready", 32'(rready), 32'd0);
        chk("RST req_ready", 32'(req_ready), 32'd1);
        chk("RST resp_valid", 32'(resp_valid), 32'd0);
        chk("RST arvalid", 32'(arvalid), 32'd0);
        chk("RST resp_rdata", resp_rdata, 32'd0);
        step();
        chk("RST no late resp", 32'(resp_valid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
